// File: rtl/ps2_pkg.sv
// Shared constants, state encodings and event layout for the PS/2 key-event tracker.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam int         PS2_EVT_W = 10;

  // Bytes that carry no key information: error, BAT-ok, pause prefix, overrun.
  localparam int         PS2_IGN_N   = 4;
  localparam logic [PS2_IGN_N*8-1:0] PS2_IGNORED = {8'hFF, 8'hE1, 8'hAA, 8'h00};

  typedef enum logic [1:0] {
    PFX_NONE = 2'd0,
    PFX_E0   = 2'd1,
    PFX_F0   = 2'd2,
    PFX_E0F0 = 2'd3
  } pfx_t;

  typedef enum logic [1:0] {
    FS_FETCH = 2'd0,
    FS_ACK   = 2'd1,
    FS_WAIT  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  function automatic logic is_ignored(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < PS2_IGN_N; i++) begin
      if (b == PS2_IGNORED[i*8 +: 8]) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic pfx_t next_pfx(input pfx_t cur, input logic [7:0] b);
    pfx_t nxt;
    nxt = PFX_NONE;
    if (b == PS2_EXT) begin
      nxt = PFX_E0;
    end else if (b == PS2_BRK) begin
      case (cur)
        PFX_NONE: nxt = PFX_F0;
        PFX_E0:   nxt = PFX_E0F0;
        default:  nxt = cur;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word fall-through event FIFO; a pop in the same cycle frees room for a push when full.
module ps2_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             push_ok
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign push_ok = do_push;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; empty gates the head so stale words never show.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 scan-code fetch, prefix decode, held-key tracking and event FIFO.
// Define PS2_TYPEMATIC_FILTER_EN to suppress repeated make events of the held key.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       kbd_data,
  input  logic             kbd_ready,
  input  logic             kbd_overflow,
  output logic             kbd_nextdata_n,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_break,
  output logic [7:0]       cur_code,
  output logic             cur_ext,
  output logic             key_held,
  output logic [CNT_W-1:0] press_count,
  output logic [7:0]       drop_count,
  output logic             rx_overflow
);

  fetch_state_t state;
  pfx_t         pfx;
  logic [7:0]   rx_byte;

  ps2_evt_t evt;
  ps2_evt_t head;
  logic     emit;
  logic     held_match;
  logic     push_req;
  logic     push_ok;
  logic     fifo_full;
  logic     fifo_empty;
  logic     drop;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= FS_FETCH;
      pfx            <= PFX_NONE;
      rx_byte        <= 8'h00;
      kbd_nextdata_n <= 1'b1;
    end else begin
      case (state)
        FS_FETCH: begin
          if (kbd_ready) begin
            rx_byte        <= kbd_data;
            kbd_nextdata_n <= 1'b0;
            state          <= FS_ACK;
          end
        end
        FS_ACK: begin
          kbd_nextdata_n <= 1'b1;
          pfx            <= next_pfx(pfx, rx_byte);
          state          <= FS_WAIT;
        end
        FS_WAIT: state <= FS_FETCH;
        default: begin
          kbd_nextdata_n <= 1'b1;
          state          <= FS_FETCH;
        end
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    evt      = '0;
    evt.code = rx_byte;
    evt.ext  = (pfx == PFX_E0) || (pfx == PFX_E0F0);
    evt.brk  = (pfx == PFX_F0) || (pfx == PFX_E0F0);
    emit     = (state == FS_ACK) && (rx_byte != PS2_EXT) &&
               (rx_byte != PS2_BRK) && !is_ignored(rx_byte);
  end

  assign held_match = key_held && (evt.code == cur_code) && (evt.ext == cur_ext);

`ifdef PS2_TYPEMATIC_FILTER_EN
  assign push_req = emit && !(!evt.brk && held_match);
`else
  assign push_req = emit;
`endif

  assign drop = push_req && !push_ok;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur_code    <= 8'h00;
      cur_ext     <= 1'b0;
      key_held    <= 1'b0;
      press_count <= '0;
      drop_count  <= 8'h00;
      rx_overflow <= 1'b0;
    end else begin
      if (emit) begin
        if (!evt.brk) begin
          cur_code <= evt.code;
          cur_ext  <= evt.ext;
          key_held <= 1'b1;
        end else begin
          press_count <= press_count + CNT_W'(1);
          // A release of some other key leaves the held key in place.
          if (held_match) begin
            cur_code <= 8'h00;
            cur_ext  <= 1'b0;
            key_held <= 1'b0;
          end
        end
      end
      if (drop && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
      if (kbd_overflow) rx_overflow <= 1'b1;
    end
  end

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PS2_EVT_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_req),
    .push_data (evt),
    .pop       (evt_ready),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .push_ok   (push_ok)
  );

  assign evt_valid = !fifo_empty;
  assign evt_code  = head.code;
  assign evt_ext   = head.ext;
  assign evt_break = head.brk;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Randomized and directed bench for ps2_key_tracker against a byte-level behavioural model.
module tb_ps2_key_tracker;

  localparam int DEPTH = 4;
  localparam int CW    = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    kbd_data = 8'h00;
  logic          kbd_ready = 1'b0;
  logic          kbd_overflow = 1'b0;
  logic          kbd_nextdata_n;
  logic          evt_valid;
  logic          evt_ready = 1'b0;
  logic [7:0]    evt_code;
  logic          evt_ext;
  logic          evt_break;
  logic [7:0]    cur_code;
  logic          cur_ext;
  logic          key_held;
  logic [CW-1:0] press_count;
  logic [7:0]    drop_count;
  logic          rx_overflow;

  always #5 clock = ~clock;

  ps2_key_tracker #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clock          (clock),
    .reset          (reset),
    .kbd_data       (kbd_data),
    .kbd_ready      (kbd_ready),
    .kbd_overflow   (kbd_overflow),
    .kbd_nextdata_n (kbd_nextdata_n),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_code       (evt_code),
    .evt_ext        (evt_ext),
    .evt_break      (evt_break),
    .cur_code       (cur_code),
    .cur_ext        (cur_ext),
    .key_held       (key_held),
    .press_count    (press_count),
    .drop_count     (drop_count),
    .rx_overflow    (rx_overflow)
  );

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Receiver stand-in and consumer
  logic [7:0] src_q[$];
  logic [9:0] log_q[$];
  bit         rand_en   = 1'b0;
  logic       man_ready = 1'b1;

  always @(negedge clock) begin
    if (reset && !kbd_nextdata_n && src_q.size() > 0) void'(src_q.pop_front());
    kbd_ready = (src_q.size() > 0);
    kbd_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
  end

  always @(negedge clock) begin
    evt_ready = rand_en ? 1'($urandom_range(0, 1)) : man_ready;
    if (reset && evt_valid && evt_ready) log_q.push_back({evt_ext, evt_break, evt_code});
  end

  // Behavioural model: byte stream in, event queue and key state out
  logic [9:0]    m_q[$];
  logic [7:0]    m_cur   = 8'h00;
  logic          m_ext   = 1'b0;
  logic          m_held  = 1'b0;
  logic [CW-1:0] m_press = '0;
  int            m_drop  = 0;
  logic          m_ovf   = 1'b0;
  logic          m_e0    = 1'b0;
  logic          m_f0    = 1'b0;
  int            m_cool  = 0;
  logic          m_pend  = 1'b0;
  logic [7:0]    m_byte  = 8'h00;
  logic          m_strobe = 1'b0;
  int            m_sz;
  bit            m_popped;

  task automatic model_decode(input logic [7:0] b, input int sz, input bit popped);
    logic [9:0] e;
    bit         filt;
    if (b == 8'hE0) begin
      m_e0 = 1'b1;
      m_f0 = 1'b0;
    end else if (b == 8'hF0) begin
      m_f0 = 1'b1;
    end else if (b == 8'h00 || b == 8'hAA || b == 8'hE1 || b == 8'hFF) begin
      m_e0 = 1'b0;
      m_f0 = 1'b0;
    end else begin
      e    = {m_e0, m_f0, b};
      m_e0 = 1'b0;
      m_f0 = 1'b0;
      filt = 1'b0;
      if (!e[8]) begin
`ifdef PS2_TYPEMATIC_FILTER_EN
        filt = m_held && (m_cur == b) && (m_ext == e[9]);
`endif
        m_cur  = b;
        m_ext  = e[9];
        m_held = 1'b1;
      end else begin
        m_press = m_press + CW'(1);
        if (m_held && m_cur == b && m_ext == e[9]) begin
          m_held = 1'b0;
          m_cur  = 8'h00;
          m_ext  = 1'b0;
        end
      end
      if (!filt) begin
        if (sz < DEPTH || popped) m_q.push_back(e);
        else if (m_drop < 255) m_drop++;
      end
    end
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_cur = 8'h00; m_ext = 1'b0; m_held = 1'b0; m_press = '0; m_drop = 0;
      m_ovf = 1'b0; m_e0 = 1'b0; m_f0 = 1'b0; m_cool = 0; m_pend = 1'b0; m_strobe = 1'b0;
    end else begin
      m_sz     = m_q.size();
      m_popped = evt_ready && (m_sz > 0);
      if (m_popped) void'(m_q.pop_front());
      if (kbd_overflow) m_ovf = 1'b1;
      if (m_pend) begin
        model_decode(m_byte, m_sz, m_popped);
        m_pend = 1'b0;
      end
      // A byte is taken, then the receiver gets two cycles before the next look.
      if (m_cool > 0) begin
        m_cool--;
        m_strobe = 1'b0;
      end else if (kbd_ready) begin
        m_byte   = kbd_data;
        m_pend   = 1'b1;
        m_cool   = 2;
        m_strobe = 1'b1;
      end else begin
        m_strobe = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      check("nextdata_n", 32'(kbd_nextdata_n), 32'(!m_strobe));
      check("evt_valid", 32'(evt_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) check("evt_head", 32'({evt_ext, evt_break, evt_code}), 32'(m_q[0]));
      check("cur_code", 32'(cur_code), 32'(m_cur));
      check("cur_ext", 32'(cur_ext), 32'(m_ext));
      check("key_held", 32'(key_held), 32'(m_held));
      check("press_count", 32'(press_count), 32'(m_press));
      check("drop_count", 32'(drop_count), 32'(m_drop));
      check("rx_overflow", 32'(rx_overflow), 32'(m_ovf));
    end
  end

  // Directed helpers
  task automatic send(input logic [7:0] b[$]);
    foreach (b[i]) src_q.push_back(b[i]);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (src_q.size() > 0 && n < 400) begin
      @(posedge clock);
      n++;
    end
    repeat (6) @(posedge clock);
    #1;
    check("src_drain_timeout", 32'(n < 400), 32'd1);
  endtask

  task automatic check_reset_outputs();
    check("rst_nextdata_n", 32'(kbd_nextdata_n), 32'd1);
    check("rst_evt_valid", 32'(evt_valid), 32'd0);
    check("rst_evt_fields", 32'({evt_ext, evt_break, evt_code}), 32'd0);
    check("rst_cur", 32'({cur_ext, cur_code}), 32'd0);
    check("rst_key_held", 32'(key_held), 32'd0);
    check("rst_press_count", 32'(press_count), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    check("rst_rx_overflow", 32'(rx_overflow), 32'd0);
  endtask

  initial begin
    logic [7:0] seq[$];
    int n;

    // Power-on reset
    #12;
    check_reset_outputs();
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (3) @(posedge clock); #1;

    // Make then break of a plain key
    log_q.delete();
    seq = '{8'h1C, 8'hF0, 8'h1C};
    send(seq);
    wait_drain();
    check("t1_events", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      check("t1_ev0", 32'(log_q[0]), 32'h01C);
      check("t1_ev1", 32'(log_q[1]), 32'h11C);
    end
    check("t1_key_held", 32'(key_held), 32'd0);
    check("t1_press", 32'(press_count), 32'd1);

    // Extended make and break
    log_q.delete();
    seq = '{8'hE0, 8'h75};
    send(seq);
    wait_drain();
    check("t2_cur_ext_held", 32'({key_held, cur_ext, cur_code}), 32'h375);
    seq = '{8'hE0, 8'hF0, 8'h75};
    send(seq);
    wait_drain();
    check("t2_events", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      check("t2_ev0", 32'(log_q[0]), 32'h275);
      check("t2_ev1", 32'(log_q[1]), 32'h375);
    end
    check("t2_press", 32'(press_count), 32'd2);

    // Typematic repeats
    log_q.delete();
    seq = '{8'h1B, 8'h1B, 8'h1B, 8'hF0, 8'h1B};
    send(seq);
    wait_drain();
`ifdef PS2_TYPEMATIC_FILTER_EN
    check("t3_events", 32'(log_q.size()), 32'd2);
`else
    check("t3_events", 32'(log_q.size()), 32'd4);
`endif
    check("t3_key_held", 32'(key_held), 32'd0);

    // Overfill with the consumer stalled, then a push that coincides with a pop
    log_q.delete();
    man_ready = 1'b0;
    seq = '{8'h15, 8'h16, 8'h17, 8'h18, 8'h19, 8'h1A};
    send(seq);
    wait_drain();
    check("t4_drop", 32'(drop_count), 32'd2);
    check("t4_valid", 32'(evt_valid), 32'd1);
    seq = '{8'h1D};
    send(seq);
    n = 0;
    while (kbd_nextdata_n && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    check("t4_strobe_timeout", 32'(n < 50), 32'd1);
    man_ready = 1'b1;
    @(posedge clock); #1;
    man_ready = 1'b0;
    wait_drain();
    check("t4_drop_after_sim", 32'(drop_count), 32'd2);
    man_ready = 1'b1;
    repeat (10) @(posedge clock); #1;
    check("t4_drained", 32'(log_q.size()), 32'd5);
    if (log_q.size() == 5) begin
      check("t4_d0", 32'(log_q[0]), 32'h015);
      check("t4_d1", 32'(log_q[1]), 32'h016);
      check("t4_d2", 32'(log_q[2]), 32'h017);
      check("t4_d3", 32'(log_q[3]), 32'h018);
      check("t4_d4", 32'(log_q[4]), 32'h01D);
    end

    // Reset in the middle of a prefix
    seq = '{8'hE0, 8'hF0};
    send(seq);
    wait_drain();
    #1 reset = 1'b0;
    #1 check_reset_outputs();
    @(posedge clock); #1;
    reset = 1'b1;
    log_q.delete();
    seq = '{8'h1C};
    send(seq);
    wait_drain();
    check("t5_events", 32'(log_q.size()), 32'd1);
    if (log_q.size() == 1) check("t5_ev0", 32'(log_q[0]), 32'h01C);

    // press_count wrap at 4 bits
    for (int i = 0; i < 15; i++) begin
      seq = '{8'hF0, 8'(8'h20 + i)};
      send(seq);
    end
    wait_drain();
    check("t6_press_15", 32'(press_count), 32'd15);
    seq = '{8'hF0, 8'h3A};
    send(seq);
    wait_drain();
    check("t6_press_wrap", 32'(press_count), 32'd0);

    // Sticky overflow
    kbd_overflow = 1'b1;
    @(posedge clock); #1;
    kbd_overflow = 1'b0;
    repeat (4) @(posedge clock); #1;
    check("t6_rx_overflow", 32'(rx_overflow), 32'd1);

    // Randomized traffic with a randomly stalling consumer
    rand_en = 1'b1;
    for (int blk = 0; blk < 20; blk++) begin
      for (int i = 0; i < 20; i++) begin
        case ($urandom_range(0, 9))
          0:       src_q.push_back(8'hE0);
          1, 2:    src_q.push_back(8'hF0);
          3: begin
            case ($urandom_range(0, 3))
              0:       src_q.push_back(8'h00);
              1:       src_q.push_back(8'hAA);
              2:       src_q.push_back(8'hE1);
              default: src_q.push_back(8'hFF);
            endcase
          end
          default: src_q.push_back(8'(8'h15 + $urandom_range(0, 5)));
        endcase
      end
      wait_drain();
    end
    rand_en = 1'b0;
    man_ready = 1'b1;
    repeat (12) @(posedge clock); #1;
    check("rand_final_empty", 32'(evt_valid), 32'd0);

    // Final reset clears everything, including the sticky flag
    reset = 1'b0;
    #2 check_reset_outputs();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
